// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: SimpleRisc opcodes, scoreboard indices and decode helpers
package simplerisc_pkg;
   localparam int NREG = 16;
   localparam logic [4:0] RA    = 5'd15;
   localparam logic [4:0] FLAGS = 5'd16;
   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_MOD  = 5'd4;
   localparam logic [4:0] OP_CMP  = 5'd5;
   localparam logic [4:0] OP_AND  = 5'd6;
   localparam logic [4:0] OP_OR   = 5'd7;
   localparam logic [4:0] OP_NOT  = 5'd8;
   localparam logic [4:0] OP_MOV  = 5'd9;
   localparam logic [4:0] OP_LSL  = 5'd10;
   localparam logic [4:0] OP_LSR  = 5'd11;
   localparam logic [4:0] OP_ASR  = 5'd12;
   localparam logic [4:0] OP_NOP  = 5'd13;
   localparam logic [4:0] OP_LD   = 5'd14;
   localparam logic [4:0] OP_ST   = 5'd15;
   localparam logic [4:0] OP_BEQ  = 5'd16;
   localparam logic [4:0] OP_BGT  = 5'd17;
   localparam logic [4:0] OP_B    = 5'd18;
   localparam logic [4:0] OP_CALL = 5'd19;
   localparam logic [4:0] OP_RET  = 5'd20;

   typedef enum logic {RUN, BR_WAIT} state_e;

   function automatic logic writes_reg(input logic [4:0] op);
      return op <= OP_MOD || (op >= OP_AND && op <= OP_ASR) || op == OP_LD;
   endfunction

   function automatic logic reads_rs1(input logic [4:0] op);
      return op <= OP_OR || (op >= OP_LSL && op <= OP_ASR) || op == OP_LD || op == OP_ST;
   endfunction

   // every ALU op up to asr (including not/mov) takes rs2 unless the immediate replaces it
   function automatic logic reads_rs2(input logic [4:0] op, input logic imm);
      return !imm && op <= OP_ASR;
   endfunction

   function automatic logic is_branch(input logic [4:0] op);
      return op >= OP_BEQ && op <= OP_RET;
   endfunction
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: pending-write bits for r0..r15 plus flags; ISSUE_CTRL_WB_BYPASS_EN exposes same-cycle clears
module issue_scoreboard
   import simplerisc_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          set_i,
   input  logic [4:0]    set_idx_i,
   input  logic          wb_valid_i,
   input  logic [3:0]    wb_rd_i,
   input  logic          wb_flags_i,
   output logic [NREG:0] busy_o
);
   logic [NREG:0] pend_q, pend_d, set_v, clr_v;

   // a set in the same cycle as a clear of the same bit keeps the bit pending
   always_comb begin
      set_v = '0;
      clr_v = '0;
      set_v[set_idx_i] = set_i;
      clr_v[{1'b0, wb_rd_i}] = wb_valid_i;
      clr_v[FLAGS] = wb_flags_i;
      pend_d = (pend_q & ~clr_v) | set_v;
   end

   // pending bits register
   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else pend_q <= pend_d;
   end

`ifdef ISSUE_CTRL_WB_BYPASS_EN
   assign busy_o = pend_q & ~clr_v;
`else
   assign busy_o = pend_q;
`endif
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order single-issue controller with scoreboard hazards and branch shadow; option ISSUE_CTRL_WB_BYPASS_EN
module issue_ctrl
   import simplerisc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [4:0]       id_opcode,
   input  logic             id_imm,
   input  logic [3:0]       id_rd,
   input  logic [3:0]       id_rs1,
   input  logic [3:0]       id_rs2,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [4:0]       ex_opcode,
   output logic             ex_imm,
   output logic [3:0]       ex_rd,
   output logic [3:0]       ex_rs1,
   output logic [3:0]       ex_rs2,
   input  logic             wb_valid,
   input  logic [3:0]       wb_rd,
   input  logic             wb_flags,
   input  logic             br_resolve,
   input  logic             br_taken,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);
   state_e           state_q;
   logic             ex_valid_q, flush_q, ex_imm_q;
   logic [4:0]       ex_opcode_q;
   logic [3:0]       ex_rd_q, ex_rs1_q, ex_rs2_q;
   logic [CNT_W-1:0] stall_q;
   logic [NREG:0]    busy, need;
   logic [4:0]       tgt;
   logic             tgt_en, issue;

   issue_scoreboard u_sb (
      .clk        (clk),
      .rst        (rst),
      .set_i      (issue & tgt_en),
      .set_idx_i  (tgt),
      .wb_valid_i (wb_valid),
      .wb_rd_i    (wb_rd),
      .wb_flags_i (wb_flags),
      .busy_o     (busy)
   );

   // every source and the write target of the decode slot, as scoreboard bits
   always_comb begin
      tgt = id_opcode == OP_CALL ? RA : id_opcode == OP_CMP ? FLAGS : {1'b0, id_rd};
      tgt_en = writes_reg(id_opcode) || id_opcode == OP_CALL || id_opcode == OP_CMP;
      need = '0;
      if (reads_rs1(id_opcode)) need[{1'b0, id_rs1}] = 1'b1;
      if (reads_rs2(id_opcode, id_imm)) need[{1'b0, id_rs2}] = 1'b1;
      if (id_opcode == OP_ST) need[{1'b0, id_rd}] = 1'b1;
      if (id_opcode == OP_RET) need[RA] = 1'b1;
      if (id_opcode == OP_BEQ || id_opcode == OP_BGT) need[FLAGS] = 1'b1;
      if (tgt_en) need[tgt] = 1'b1;
   end

   assign issue = id_valid && !(|(need & busy)) && state_q == RUN && (!ex_valid_q || ex_ready) && !flush_q;

   // issue register, branch-shadow FSM, flush pulse and stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         ex_valid_q  <= 1'b0;
         ex_opcode_q <= '0;
         ex_imm_q    <= 1'b0;
         ex_rd_q     <= '0;
         ex_rs1_q    <= '0;
         ex_rs2_q    <= '0;
         flush_q     <= 1'b0;
         stall_q     <= '0;
      end else begin
         flush_q <= br_resolve && br_taken;
         if (issue) begin
            ex_valid_q  <= 1'b1;
            ex_opcode_q <= id_opcode;
            ex_imm_q    <= id_imm;
            ex_rd_q     <= id_rd;
            ex_rs1_q    <= id_rs1;
            ex_rs2_q    <= id_rs2;
         end else if (ex_ready) ex_valid_q <= 1'b0;
         if (issue && is_branch(id_opcode)) state_q <= BR_WAIT;
         else if (br_resolve) state_q <= RUN;
         if (id_valid && !issue && !flush_q && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign id_ready  = issue;
   assign ex_valid  = ex_valid_q;
   assign ex_opcode = ex_opcode_q;
   assign ex_imm    = ex_imm_q;
   assign ex_rd     = ex_rd_q;
   assign ex_rs1    = ex_rs1_q;
   assign ex_rs2    = ex_rs2_q;
   assign flush     = flush_q;
   assign stall_cnt = stall_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed vector table plus hand sequences for issue_ctrl (honours ISSUE_CTRL_WB_BYPASS_EN)
module tb_issue_ctrl;
`ifdef ISSUE_CTRL_WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, id_valid, id_ready, id_imm, ex_valid, ex_ready, ex_imm;
   logic wb_valid, wb_flags, br_resolve, br_taken, flush;
   logic [4:0] id_opcode, ex_opcode;
   logic [3:0] id_rd, id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, wb_rd;
   logic [3:0] stall_cnt;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   issue_ctrl #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode), .id_imm(id_imm),
      .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_imm(ex_imm),
      .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_flags(wb_flags),
      .br_resolve(br_resolve), .br_taken(br_taken),
      .flush(flush), .stall_cnt(stall_cnt)
   );

   typedef struct packed {
      logic iv; logic [4:0] op; logic imm; logic [3:0] rd, rs1, rs2;
      logic exr, wbv; logic [3:0] wbrd; logic wbf, brr, brt;
      logic [11:0] exp;
   } vec_t;

   vec_t v [17];

   function automatic vec_t mk(input logic iv, input logic [4:0] op, input logic imm,
                               input logic [3:0] rd, rs1, rs2, input logic exr, wbv,
                               input logic [3:0] wbrd, input logic wbf, brr, brt, idr, exv,
                               input logic [4:0] eop, input logic [3:0] erd, input logic efl);
      mk = {iv, op, imm, rd, rs1, rs2, exr, wbv, wbrd, wbf, brr, brt, idr, exv, eop, erd, efl};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv(input logic iv, input logic [4:0] op, input logic imm, input logic [3:0] rd, rs1, rs2);
      id_valid = iv; id_opcode = op; id_imm = imm; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0);
      ex_ready = 1; wb_valid = 0; wb_rd = 0; wb_flags = 0; br_resolve = 0; br_taken = 0;
   endtask

   task automatic do_reset();
      rst = 1; idle();
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic r;
      int issue_c;
      // mov r6,#5 / ld r7,[r8] back-to-back; cmp/beq stall on flags; taken-branch flush; ex_ready held low 4 cycles
      v[0]  = mk(1, 9,1,6,0,0, 1,0,0,0,0,0, 1,0, 0,0,0);
      v[1]  = mk(1,14,0,7,8,0, 1,0,0,0,0,0, 1,1, 9,6,0);
      v[2]  = mk(1, 5,0,0,1,2, 1,1,6,0,0,0, 1,1,14,7,0);
      v[3]  = mk(1,16,0,0,0,0, 1,0,0,0,0,0, 0,1, 5,0,0);
      v[4]  = mk(0,16,0,0,0,0, 1,0,0,1,0,0, 0,0, 5,0,0);
      v[5]  = mk(1,16,0,0,0,0, 1,0,0,0,0,0, 1,0, 5,0,0);
      v[6]  = mk(1, 0,0,1,2,3, 1,0,0,0,0,0, 0,1,16,0,0);
      v[7]  = mk(1, 0,0,1,2,3, 1,0,0,0,1,1, 0,0,16,0,0);
      v[8]  = mk(1, 0,0,1,2,3, 1,0,0,0,0,0, 0,0,16,0,1);
      v[9]  = mk(1, 1,0,4,1,5, 1,0,0,0,0,0, 1,0,16,0,0);
      for (int i = 10; i < 14; i++) v[i] = mk(1,7,0,5,2,3, 0,0,0,0,0,0, 0,1,1,4,0);
      v[14] = mk(1, 7,0,5,2,3, 1,0,0,0,0,0, 1,1, 1,4,0);
      v[15] = mk(0, 0,0,0,0,0, 1,0,0,0,0,0, 0,1, 7,5,0);
      v[16] = mk(0, 0,0,0,0,0, 1,0,0,0,0,0, 0,0, 7,5,0);

      do_reset();
      rst = 1; #1;
      chk("reset_state", {id_ready, ex_valid, ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_imm, flush, stall_cnt}, 0);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 17; i++) begin
         drv(v[i].iv, v[i].op, v[i].imm, v[i].rd, v[i].rs1, v[i].rs2);
         ex_ready = v[i].exr; wb_valid = v[i].wbv; wb_rd = v[i].wbrd;
         wb_flags = v[i].wbf; br_resolve = v[i].brr; br_taken = v[i].brt;
         #1;
         chk($sformatf("vec%0d {idr,exv,op,rd,flush}", i), {id_ready, ex_valid, ex_opcode, ex_rd, flush}, v[i].exp);
         @(negedge clk);
      end
      idle(); #1;
      chk("table_stall_cnt", stall_cnt, 7);

      // call sets r15 and enters BR_WAIT; not-taken resolve gives no flush; ret waits for r15 writeback
      do_reset();
      drv(1, 19, 0, 0, 0, 0); #1;
      chk("call_rdy", id_ready, 1);
      @(negedge clk);
      drv(1, 20, 0, 0, 0, 0); br_resolve = 1; br_taken = 0; #1;
      chk("ret_brwait_rdy", id_ready, 0);
      @(negedge clk);
      br_resolve = 0; #1;
      chk("ntaken_flush_rdy", {flush, id_ready}, 0);
      @(negedge clk);
      wb_valid = 1; wb_rd = 15; #1;
      chk("ret_wb_rdy", id_ready, BYP);
      r = id_ready;
      @(negedge clk);
      wb_valid = 0;
      if (!r) begin
         #1;
         chk("ret_after_wb_rdy", id_ready, 1);
         @(negedge clk);
      end
      chk("ret_issued", {ex_valid, ex_opcode}, {1'b1, 5'd20});

      // add r1,r2,r3 then sub r4,r1,r5 with r1 written back three cycles later
      do_reset();
      drv(1, 0, 0, 1, 2, 3); #1;
      chk("raw_add_rdy", id_ready, 1);
      @(negedge clk);
      drv(1, 1, 0, 4, 1, 5);
      issue_c = -1;
      for (int c = 1; c <= 8 && issue_c < 0; c++) begin
         wb_valid = (c == 3); wb_rd = 1; #1;
         if (id_ready) issue_c = c;
         @(negedge clk);
      end
      idle();
      chk("raw_issue_cycle", issue_c, BYP ? 3 : 4);
      chk("raw_stall_cnt", stall_cnt, BYP ? 2 : 3);
      chk("raw_ex_sub", {ex_valid, ex_opcode, ex_rd}, {1'b1, 5'd1, 4'd4});

      // reset while r3 pending and in BR_WAIT, with a taken resolve in the reset cycle
      do_reset();
      drv(1, 0, 0, 3, 1, 2); #1;
      chk("rst_add_rdy", id_ready, 1);
      @(negedge clk);
      drv(1, 18, 0, 0, 0, 0); #1;
      chk("rst_b_rdy", id_ready, 1);
      @(negedge clk);
      drv(1, 0, 0, 1, 3, 2); #1;
      chk("rst_brwait_rdy", id_ready, 0);
      rst = 1; br_resolve = 1; br_taken = 1;
      @(negedge clk);
      rst = 0; br_resolve = 0; br_taken = 0; #1;
      chk("rst_cleared", {ex_valid, flush, stall_cnt, id_ready}, {1'b0, 1'b0, 4'd0, 1'b1});
      @(negedge clk);
      chk("rst_dep_issued", {ex_valid, ex_opcode, ex_rd}, {1'b1, 5'd0, 4'd1});

      // stall counter saturates at all-ones
      do_reset();
      drv(1, 0, 0, 1, 2, 3);
      @(negedge clk);
      drv(1, 1, 0, 4, 1, 5);
      repeat (20) @(negedge clk);
      #1;
      chk("stall_saturate", stall_cnt, 15);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
